fifo_drain_arbiter: RTL and testbench

- Shares one downstream valid/ready consumer among NUM_Q fifo instances.
- Issues rd pops to the fifos in weighted round-robin order, with up to BURST_LEN consecutive pops per grant.
- Registers each popped word with its queue id.
- Never issues rd to a queue whose wr is asserted in the same cycle, because the fifo ignores rd while wr is high.

---
 rtl/fifo_drain_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// Weighted round-robin drain of NUM_Q fifos into one registered valid/ready stream.
// Define FIFO_DRAIN_ARB_STRICT_Q0_EN to give queue 0 strict, uncapped priority.
module fifo_drain_arbiter #(
  parameter int NUM_Q     = 4,
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 2,
  parameter int QID_W     = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_Q-1:0]       q_en,
  input  logic [NUM_Q-1:0]       fifo_empty,
  input  logic [NUM_Q-1:0]       fifo_wr,
  input  logic [NUM_Q*WIDTH-1:0] fifo_data,
  output logic [NUM_Q-1:0]       fifo_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [QID_W-1:0]       out_qid
);

`ifdef FIFO_DRAIN_ARB_STRICT_Q0_EN
  localparam bit STRICT_Q0 = 1'b1;
`else
  localparam bit STRICT_Q0 = 1'b0;
`endif
  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           r_state, w_state_nxt;
  logic [QID_W-1:0] r_rr_ptr, w_rr_nxt;
  logic [QID_W-1:0] r_cur_q, w_cur_nxt;
  logic [3:0]       r_burst_cnt, w_cnt_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [QID_W-1:0] r_out_qid;

  logic [NUM_Q-1:0] w_elig, w_search_mask;
  logic [QID_W-1:0] w_search_start, w_found_q, w_grant_q;
  logic             w_found, w_grant, w_load, w_q0_burst, w_rr_burst;

  function automatic logic [QID_W-1:0] wrap_add(input logic [QID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_Q) s = s - NUM_Q;
    return QID_W'(s);
  endfunction

  // A queue being written this cycle would ignore rd, so it is not eligible.
  assign w_elig     = q_en & ~fifo_empty & ~fifo_wr;
  assign w_load     = !r_out_valid || out_ready;
  assign w_q0_burst = STRICT_Q0 && (r_cur_q == '0);
  assign w_rr_burst = (r_state == BURST) && !w_q0_burst;

  // Queue 0 bursts sit outside the rotation, so their end leaves rr_ptr alone.
  assign w_search_start = w_rr_burst ? wrap_add(r_cur_q, 1) : r_rr_ptr;
  assign w_search_mask  = w_elig & ~NUM_Q'(STRICT_Q0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_found   = 1'b0;
    w_found_q = '0;
    for (int k = NUM_Q - 1; k >= 0; k--) begin
      if (w_search_mask[wrap_add(w_search_start, k)]) begin
        w_found   = 1'b1;
        w_found_q = wrap_add(w_search_start, k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_cur_nxt   = r_cur_q;
    w_cnt_nxt   = r_burst_cnt;
    w_grant     = 1'b0;
    w_grant_q   = r_cur_q;
    if (w_load) begin
      if (STRICT_Q0 && w_elig[0]) begin
        w_grant     = 1'b1;
        w_grant_q   = '0;
        w_cur_nxt   = '0;
        w_cnt_nxt   = 4'd1;
        w_state_nxt = BURST;
      end else if (w_rr_burst && w_elig[r_cur_q] && (r_burst_cnt < BURST_MAX)) begin
        w_grant   = 1'b1;
        w_grant_q = r_cur_q;
        w_cnt_nxt = r_burst_cnt + 4'd1;
      end else begin
        if (w_rr_burst) w_rr_nxt = wrap_add(r_cur_q, 1);
        if (w_found) begin
          w_grant   = 1'b1;
          w_grant_q = w_found_q;
          w_cur_nxt = w_found_q;
          w_cnt_nxt = 4'd1;
          if (BURST_LEN > 1) begin
            w_state_nxt = BURST;
          end else begin
            w_state_nxt = IDLE;
            w_rr_nxt    = wrap_add(w_found_q, 1);
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
    end
  end

  always_comb begin
    fifo_rd = '0;
    if (resetn && w_grant) fifo_rd[w_grant_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_cur_q     <= '0;
      r_burst_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_qid   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_cur_q     <= w_cur_nxt;
      r_burst_cnt <= w_cnt_nxt;
      if (w_load) begin
        if (w_grant) begin
          r_out_valid <= 1'b1;
          r_out_data  <= fifo_data[int'(w_grant_q)*WIDTH +: WIDTH];
          r_out_qid   <= w_grant_q;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_qid   = r_out_qid;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Scoreboard bench for fifo_drain_arbiter: behavioural fifos feed the DUT,
// expected words are queued with the stimulus and checked by a separate monitor.
module tb_fifo_drain_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  q_en, fifo_empty, fifo_wr, fifo_rd;
  logic [31:0] fifo_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_qid;

  typedef struct packed {
    logic [1:0] qid;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem[4][16];
  int         hd[4];
  int         cnt[4];
  logic [7:0] wdata[4];
  int         n_cmp = 0;
  int         n_fail = 0;

  fifo_drain_arbiter #(.NUM_Q(4), .WIDTH(8), .BURST_LEN(2), .QID_W(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .q_en      (q_en),
    .fifo_empty(fifo_empty),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_qid   (out_qid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]       = (cnt[i] == 0);
      fifo_data[i*8 +: 8] = (cnt[i] == 0) ? 8'h00 : mem[i][hd[i]];
    end
  endtask

  task automatic push(input int q, input logic [7:0] d);
    mem[q][(hd[q] + cnt[q]) % 16] = d;
    cnt[q]++;
    refresh();
  endtask

  task automatic expect_word(input logic [1:0] q, input logic [7:0] d);
    exp_q.push_back({q, d});
  endtask

  // One clock: sample DUT strobes on the falling edge, update the fifo models after the rising edge.
  task automatic tick(input logic [3:0] exp_rd, input bit chk);
    logic [3:0] rd_s, wr_s;
    refresh();
    @(negedge clk);
    rd_s = fifo_rd;
    wr_s = fifo_wr;
    if (chk) check("fifo_rd", 32'(rd_s), 32'(exp_rd));
    check("rd_onehot0", 32'($onehot0(rd_s)), 32'd1);
    check("rd_during_wr", 32'(rd_s & wr_s), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (wr_s[i]) begin
        push(i, wdata[i]);
      end else if (rd_s[i]) begin
        check("pop_of_empty_fifo", 32'(cnt[i] == 0), 32'd0);
        if (cnt[i] > 0) begin
          hd[i]  = (hd[i] + 1) % 16;
          cnt[i] = cnt[i] - 1;
        end
      end
    end
    refresh();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick(4'b0000, 1'b0);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got qid=%0d data=0x%0h, expected no word", out_qid, out_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_qid", 32'(out_qid), 32'(e.qid));
        check("sb_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    q_en      = 4'hF;
    fifo_wr   = 4'h0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hd[i]    = 0;
      cnt[i]   = 0;
      wdata[i] = 8'h00;
    end
    refresh();

    // Reset, then idle with every fifo empty.
    repeat (3) tick(4'b0000, 1'b1);
    resetn = 1'b1;
    repeat (10) begin
      tick(4'b0000, 1'b1);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_qid", 32'(out_qid), 32'd0);
      check("idle_data", 32'(out_data), 32'd0);
    end

    // Burst of two on Q1, then Q2, then back to Q1.
    push(1, 8'h11); push(1, 8'h12); push(1, 8'h13); push(2, 8'h21);
    expect_word(2'd1, 8'h11); expect_word(2'd1, 8'h12);
    expect_word(2'd2, 8'h21); expect_word(2'd1, 8'h13);
    tick(4'b0010, 1'b1);
    check("t2_latency_valid", 32'(out_valid), 32'd1);
    tick(4'b0010, 1'b1);
    tick(4'b0100, 1'b1);
    tick(4'b0010, 1'b1);
    tick(4'b0000, 1'b1);
    drain("t2");

    // Backpressure: one pop, word held until accepted.
    out_ready = 1'b0;
    push(0, 8'hA0);
    expect_word(2'd0, 8'hA0);
    tick(4'b0001, 1'b1);
    check("t3_hold_valid", 32'(out_valid), 32'd1);
    check("t3_hold_data", 32'(out_data), 32'hA0);
    tick(4'b0000, 1'b1);
    check("t3_hold_data2", 32'(out_data), 32'hA0);
    check("t3_hold_qid2", 32'(out_qid), 32'd0);
    tick(4'b0000, 1'b1);
    check("t3_hold_data3", 32'(out_data), 32'hA0);
    out_ready = 1'b1;
    tick(4'b0000, 1'b1);
    check("t3_valid_falls", 32'(out_valid), 32'd0);

    // Write collision on Q3 mid-burst hands the slot to Q0.
    push(3, 8'h31); push(3, 8'h32); push(0, 8'hB0);
    expect_word(2'd3, 8'h31); expect_word(2'd0, 8'hB0);
    expect_word(2'd3, 8'h32); expect_word(2'd3, 8'h33);
    tick(4'b1000, 1'b1);
    fifo_wr  = 4'b1000;
    wdata[3] = 8'h33;
    tick(4'b0001, 1'b1);
    fifo_wr  = 4'b0000;
    tick(4'b1000, 1'b1);
    tick(4'b1000, 1'b1);
    tick(4'b0000, 1'b1);
    drain("t4");

    // Q2 disabled: it is skipped until its enable returns.
    q_en = 4'b1011;
    for (int q = 0; q < 4; q++)
      for (int k = 0; k < 4; k++) push(q, 8'(8'hC0 + q*16 + k));
    expect_word(2'd0, 8'hC0); expect_word(2'd0, 8'hC1);
    expect_word(2'd1, 8'hD0); expect_word(2'd1, 8'hD1);
    expect_word(2'd3, 8'hF0); expect_word(2'd3, 8'hF1);
    expect_word(2'd0, 8'hC2); expect_word(2'd0, 8'hC3);
    expect_word(2'd1, 8'hD2); expect_word(2'd1, 8'hD3);
    expect_word(2'd3, 8'hF2); expect_word(2'd3, 8'hF3);
    tick(4'b0001, 1'b1); tick(4'b0001, 1'b1);
    tick(4'b0010, 1'b1); tick(4'b0010, 1'b1);
    tick(4'b1000, 1'b1); tick(4'b1000, 1'b1);
    tick(4'b0001, 1'b1);
    drain("t5");
    q_en = 4'b1111;
    expect_word(2'd2, 8'hE0); expect_word(2'd2, 8'hE1);
    expect_word(2'd2, 8'hE2); expect_word(2'd2, 8'hE3);
    tick(4'b0100, 1'b1); tick(4'b0100, 1'b1);
    tick(4'b0100, 1'b1); tick(4'b0100, 1'b1);
    drain("t5_q2");

`ifdef FIFO_DRAIN_ARB_STRICT_Q0_EN
    // Queue 0 pre-empts a Q1 burst; rotation then resumes at Q2.
    push(1, 8'h51); push(1, 8'h52); push(1, 8'h53); push(1, 8'h54);
    expect_word(2'd1, 8'h51); expect_word(2'd1, 8'h52); expect_word(2'd1, 8'h53);
    expect_word(2'd0, 8'h0A); expect_word(2'd2, 8'h2A); expect_word(2'd1, 8'h54);
    tick(4'b0010, 1'b1);
    tick(4'b0010, 1'b1);
    tick(4'b0010, 1'b1);
    push(0, 8'h0A); push(2, 8'h2A);
    tick(4'b0001, 1'b1);
    tick(4'b0100, 1'b1);
    tick(4'b0010, 1'b1);
    tick(4'b0000, 1'b1);
    drain("t6");
`endif

    // Reset mid-burst: held word dropped, no pop in the reset cycle.
    push(1, 8'h61); push(1, 8'h62); push(1, 8'h63);
    tick(4'b0010, 1'b1);
    resetn = 1'b0;
    tick(4'b0000, 1'b1);
    resetn = 1'b1;
    check("t7_rst_valid", 32'(out_valid), 32'd0);
    check("t7_rst_data", 32'(out_data), 32'd0);
    expect_word(2'd1, 8'h62); expect_word(2'd1, 8'h63);
    tick(4'b0010, 1'b1);
    tick(4'b0010, 1'b1);
    tick(4'b0000, 1'b1);
    drain("t7");

    check("sb_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
